his_reader: RTL

Readout engine for the ping-pong histogram RAM filled by the histogram builder. When the builder toggles `hisNum` at the end of an acquisition, this block walks every bin of every pixel in the just-completed bank. It streams each bin count downstream over a valid/ready handshake, then clears the bin so the bank is empty before the builder reuses it. It sits between the histogram RAM's second port and the depth/peak processing stage.

---
 rtl/his_pkg.sv | 17 +
 rtl/his_peak_tracker.sv | 54 +++++
 rtl/his_reader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/his_pkg.sv
// Shared histogram constants and readout state encoding, common to builder and reader.
// Parameters here are defaults only; instances may override them.
package his_pkg;

  localparam int HIS_NB        = 8;
  localparam int HIS_COUNT_W   = 16;
  localparam int HIS_PIXEL_NUM = 200;
  localparam int HIS_PIX_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    OUT  = 2'd3
  } his_state_t;

endpackage

// File: rtl/his_peak_tracker.sv
// Per-pixel maximum finder over the readout stream; result pulses one cycle after the bin_last beat.
// Consumes only accepted beats, so it follows the stream's backpressure implicitly.
module his_peak_tracker #(
  parameter int NB      = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               res,
  input  logic               beat,
  input  logic [NB-1:0]      bin,
  input  logic [COUNT_W-1:0] count,
  input  logic               last,
  output logic               peak_valid,
  output logic [NB-1:0]      peak_bin,
  output logic [COUNT_W-1:0] peak_count
);

  logic [COUNT_W-1:0] max_cnt;
  logic [NB-1:0]      max_bin;
  logic [COUNT_W-1:0] cnt_nxt;
  logic [NB-1:0]      bin_nxt;

  // Bin 0 restarts the search; strict compare keeps the earliest bin on ties.
  always_comb begin
    cnt_nxt = max_cnt;
    bin_nxt = max_bin;
    if ((bin == '0) || (count > max_cnt)) begin
      cnt_nxt = count;
      bin_nxt = bin;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      max_cnt    <= '0;
      max_bin    <= '0;
      peak_valid <= 1'b0;
      peak_bin   <= '0;
      peak_count <= '0;
    end else begin
      peak_valid <= 1'b0;
      if (beat) begin
        max_cnt <= cnt_nxt;
        max_bin <= bin_nxt;
        if (last) begin
          peak_valid <= 1'b1;
          peak_bin   <= bin_nxt;
          peak_count <= cnt_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/his_reader.sv
// Walks and clears every bin of the completed ping-pong bank, 3 cycles/bin, first beat 3 cycles after toggle.
// Holds beat and RAM address while bin_ready is low; HIS_READER_PEAK_EN adds per-pixel peak outputs.
module his_reader
  import his_pkg::*;
#(
  parameter int NB        = HIS_NB,
  parameter int COUNT_W   = HIS_COUNT_W,
  parameter int PIXEL_NUM = HIS_PIXEL_NUM,
  parameter int PIX_W     = HIS_PIX_W
) (
  input  logic               clk,
  input  logic               res,
  input  logic               hisNum,
  output logic               ram_rd_en,
  output logic               ram_clr_en,
  output logic               ram_bank,
  output logic [PIX_W-1:0]   ram_pix,
  output logic [NB-1:0]      ram_bin,
  input  logic [COUNT_W-1:0] ram_rd_data,
  output logic               bin_valid,
  input  logic               bin_ready,
  output logic [COUNT_W-1:0] bin_data,
  output logic [NB-1:0]      bin_idx,
  output logic [PIX_W-1:0]   pix_idx,
  output logic               bin_last,
  output logic               frame_last,
  output logic               busy,
  output logic               overrun
`ifdef HIS_READER_PEAK_EN
  ,
  output logic               peak_valid,
  output logic [NB-1:0]      peak_bin,
  output logic [COUNT_W-1:0] peak_count
`endif
);

  localparam logic [NB-1:0]    BIN_MAX = {NB{1'b1}};
  localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(PIXEL_NUM - 1);

  his_state_t       state, state_nxt;
  logic             his_q;
  logic             tog;
  logic             hs;
  logic             start;
  logic             ovr_set;
  logic             frame_end;
  logic [PIX_W-1:0] pix;
  logic [NB-1:0]    bin;

  assign tog        = hisNum ^ his_q;
  assign bin_last   = (bin == BIN_MAX);
  assign frame_end  = bin_last && (pix == PIX_MAX);
  assign frame_last = frame_end;
  assign busy       = (state != IDLE);
  assign ram_clr_en = hs;
  assign ram_pix    = pix;
  assign ram_bin    = bin;
  assign pix_idx    = pix;
  assign bin_idx    = bin;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ram_rd_en = 1'b0;
    hs        = 1'b0;
    start     = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (tog) begin
          state_nxt = READ;
          start     = 1'b1;
        end
      end
      READ: begin
        ram_rd_en = 1'b1;
        ovr_set   = tog;
        state_nxt = CAPT;
      end
      CAPT: begin
        ovr_set   = tog;
        state_nxt = OUT;
      end
      OUT: begin
        ovr_set = tog;
        if (bin_ready) begin
          hs = 1'b1;
          if (frame_end) begin
            // A toggle landing on the final beat is a fresh start, not an overrun.
            if (tog) begin
              state_nxt = READ;
              start     = 1'b1;
              ovr_set   = 1'b0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            state_nxt = READ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      his_q     <= 1'b0;
      ram_bank  <= 1'b0;
      pix       <= '0;
      bin       <= '0;
      bin_data  <= '0;
      bin_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      his_q <= hisNum;
      if (start) begin
        ram_bank <= his_q;
        pix      <= '0;
        bin      <= '0;
      end else if (hs) begin
        bin <= bin + 1'b1;
        if (bin_last) begin
          pix <= frame_end ? '0 : pix + 1'b1;
        end
      end
      if (state == CAPT) begin
        bin_data  <= ram_rd_data;
        bin_valid <= 1'b1;
      end else if (hs) begin
        bin_valid <= 1'b0;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef HIS_READER_PEAK_EN
  his_peak_tracker #(
    .NB      (NB),
    .COUNT_W (COUNT_W)
  ) u_peak (
    .clk        (clk),
    .res        (res),
    .beat       (hs),
    .bin        (bin),
    .count      (bin_data),
    .last       (bin_last),
    .peak_valid (peak_valid),
    .peak_bin   (peak_bin),
    .peak_count (peak_count)
  );
`endif

endmodule
